// File: rtl/booth_arb_pkg.sv
// Shared types and helpers for booth_mult_arbiter: FSM encoding,
// rotating-priority search and the statistics counter width.
package booth_arb_pkg;

  localparam int unsigned STAT_W  = 16;
  localparam int unsigned RR_MAXN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_grant_t;

  // First set bit of valid[n-1:0] searching upward from ptr, wrapping modulo n.
  function automatic rr_grant_t rr_next(input logic [RR_MAXN-1:0] valid,
                                        input logic [2:0]         ptr,
                                        input int unsigned        n);
    rr_grant_t   res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < RR_MAXN; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && !res.found && valid[3'(j)]) begin
        res.found = 1'b1;
        res.idx   = 3'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/booth_r4_mult_comb.sv
// Combinational signed radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH.
module booth_r4_mult_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned NDIG = WIDTH / 2;

  logic [PW-1:0]  m_ext;
  logic [WIDTH:0] q_ext;
  logic [PW-1:0]  pp;

  assign m_ext = {{WIDTH{m[WIDTH-1]}}, m};
  assign q_ext = {q, 1'b0};

  // Each overlapping 3-bit group of q selects a digit in {-2,-1,0,+1,+2}.
  always_comb begin
    product = '0;
    pp      = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      case (q_ext[2*i +: 3])
        3'b001, 3'b010: pp = m_ext;
        3'b011:         pp = m_ext << 1;
        3'b100:         pp = -(m_ext << 1);
        3'b101, 3'b110: pp = -m_ext;
        default:        pp = '0;
      endcase
      product = product + (pp << (2 * i));
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NREQ requesters.
// Optional BOOTH_ARB_STATS_EN adds grant/busy-cycle counters with stat_clear.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_m,
  input  logic [NREQ*WIDTH-1:0] req_q,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product
`ifdef BOOTH_ARB_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [STAT_W-1:0]     stat_busy_cycles,
  output logic [STAT_W-1:0]     stat_grants
`endif
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     m_q, m_d, q_q, q_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_prod_q, rsp_prod_d;
  logic [2*WIDTH-1:0]   product_c;
  rr_grant_t            grant_c;
  logic [IDW-1:0]       gidx_c;
  logic                 accept_c;

  assign grant_c  = rr_next(8'(req_valid), 3'(rr_ptr_q), NREQ);
  assign gidx_c   = IDW'(grant_c.idx);
  // rst_n qualifies the accept so no requester sees a grant while held in reset.
  assign accept_c = (state_q == IDLE) && grant_c.found && rst_n;

  booth_r4_mult_comb #(.WIDTH(WIDTH)) u_mult (
    .m       (m_q),
    .q       (q_q),
    .product (product_c)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    m_d         = m_q;
    q_d         = q_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          req_ready[gidx_c] = 1'b1;
          m_d      = req_m[gidx_c*WIDTH +: WIDTH];
          q_d      = req_q[gidx_c*WIDTH +: WIDTH];
          id_d     = gidx_c;
          rr_ptr_d = (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_prod_d  = product_c;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      m_q         <= '0;
      q_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      m_q         <= m_d;
      q_q         <= q_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_prod_q;

`ifdef BOOTH_ARB_STATS_EN
  logic [STAT_W-1:0] busy_q, busy_d, grants_q, grants_d;

  // Saturating counters; a clear takes precedence over a same-cycle increment.
  always_comb begin
    busy_d   = busy_q;
    grants_d = grants_q;
    if (stat_clear) begin
      busy_d   = '0;
      grants_d = '0;
    end else begin
      if ((state_q != IDLE) && (busy_q != '1)) busy_d = busy_q + STAT_W'(1);
      if (accept_c && (grants_q != '1))        grants_d = grants_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      grants_q <= '0;
    end else begin
      busy_q   <= busy_d;
      grants_q <= grants_d;
    end
  end

  assign stat_busy_cycles = busy_q;
  assign stat_grants      = grants_q;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter (NREQ=4, WIDTH=4); stats checks
// are included when BOOTH_ARB_STATS_EN is defined.
module tb_booth_mult_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned PW    = 2 * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_m;
  logic [NREQ*WIDTH-1:0] req_q;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [PW-1:0]         rsp_product;
`ifdef BOOTH_ARB_STATS_EN
  logic                  stat_clear;
  logic [15:0]           stat_busy_cycles;
  logic [15:0]           stat_grants;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: operands/valids presented and the rotating pointer.
  int ptr_m = 0;
  int m_val[NREQ];
  int q_val[NREQ];
  bit vld[NREQ];

  booth_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_m       (req_m),
    .req_q       (req_q),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
`ifdef BOOTH_ARB_STATS_EN
    ,
    .stat_clear       (stat_clear),
    .stat_busy_cycles (stat_busy_cycles),
    .stat_grants      (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = vld[i];
      req_m[i*WIDTH +: WIDTH]   = WIDTH'(m_val[i]);
      req_q[i*WIDTH +: WIDTH]   = WIDTH'(q_val[i]);
    end
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  function automatic logic [PW-1:0] ref_prod(input int a, input int b);
    return PW'(a * b);
  endfunction

  function automatic int ref_grant();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NREQ;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  // One full arbitration round starting at a negedge in IDLE; bp = RESP stall cycles.
  task automatic do_txn(input int bp, input string tag, output int obs_id,
                        output logic [PW-1:0] obs_prod);
    int            g;
    logic [PW-1:0] exp_p;
    obs_id   = -1;
    obs_prod = '0;
    #1;
    g = ref_grant();
    if (g < 0) begin
      chk({tag, "_idle_ready"}, 64'(req_ready), 64'd0);
      @(negedge clk);
      chk({tag, "_idle_rspvalid"}, 64'(rsp_valid), 64'd0);
      return;
    end
    exp_p = ref_prod(m_val[g], q_val[g]);
    chk({tag, "_ready_onehot"}, 64'(req_ready), 64'(1) << g);
    rsp_ready = (bp == 0);
    @(negedge clk);
    chk({tag, "_calc_rspvalid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_calc_ready"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_resp_rspvalid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_resp_id"}, 64'(rsp_id), 64'(g));
    chk({tag, "_resp_prod"}, 64'(rsp_product), 64'(exp_p));
    chk({tag, "_resp_ready"}, 64'(req_ready), 64'd0);
    obs_id   = int'(rsp_id);
    obs_prod = rsp_product;
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      chk({tag, "_hold_rspvalid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_id"}, 64'(rsp_id), 64'(g));
      chk({tag, "_hold_prod"}, 64'(rsp_product), 64'(exp_p));
      chk({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_rspvalid"}, 64'(rsp_valid), 64'd0);
    ptr_m = (g + 1) % NREQ;
  endtask

  int            oid;
  logic [PW-1:0] oprod;
  int            rr_exp[6]  = '{0, 1, 2, 3, 0, 1};
  int            seq_m[9]   = '{5, 5, -3, -4, -3, -8, -8, 7, 0};
  int            seq_q[9]   = '{2, 7, -2, -2, 2, -8, 7, 7, -5};
  logic [7:0]    seq_p[9]   = '{8'h0A, 8'h23, 8'h06, 8'h08, 8'hFA, 8'h40, 8'hC8, 8'h31, 8'h00};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_m     = '0;
    req_q     = '0;
    rsp_ready = 1'b0;
`ifdef BOOTH_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b0; m_val[i] = 0; q_val[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_rspvalid", 64'(rsp_valid), 64'd0);
    chk("reset_rspid", 64'(rsp_id), 64'd0);
    chk("reset_prod", 64'(rsp_product), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesters valid continuously: strict rotation from pointer 0.
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b1; m_val[i] = i + 1; q_val[i] = -(i + 2);
    end
    drive();
    for (int t = 0; t < 6; t++) begin
      do_txn(0, "rr", oid, oprod);
      chk("rr_order", 64'(oid), 64'(rr_exp[t]));
      m_val[oid & 3] = rnd_op();
      q_val[oid & 3] = rnd_op();
      drive();
    end

    // Requester 0 alone: directed products and extremes.
    for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
    vld[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      m_val[0] = seq_m[k];
      q_val[0] = seq_q[k];
      drive();
      do_txn(0, "seq", oid, oprod);
      chk("seq_id", 64'(oid), 64'd0);
      chk("seq_const_prod", 64'(oprod), 64'(seq_p[k]));
    end

    // Backpressure: hold rsp_ready low for 5 cycles in RESP.
    vld[0] = 1'b0; vld[1] = 1'b1; m_val[1] = -7; q_val[1] = 5;
    drive();
    do_txn(5, "bp", oid, oprod);

    // Reset while requester 2's transaction is in CALC.
    vld[1] = 1'b0; vld[2] = 1'b1; m_val[2] = 3; q_val[2] = -5;
    drive();
    #1;
    chk("rst_ready_pre", 64'(req_ready), 64'h4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_calc_rspvalid", 64'(rsp_valid), 64'd0);
    chk("rst_calc_id", 64'(rsp_id), 64'd0);
    chk("rst_calc_prod", 64'(rsp_product), 64'd0);
    chk("rst_calc_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    vld[0] = 1'b1; m_val[0] = 6; q_val[0] = 6;
    drive();
    do_txn(0, "rst_after0", oid, oprod);
    chk("rst_prio0", 64'(oid), 64'd0);
    vld[0] = 1'b0;
    drive();
    do_txn(1, "rst_after2", oid, oprod);
    chk("rst_reaccept2", 64'(oid), 64'd2);

    // Reset while a response is held in RESP.
    vld[2] = 1'b0; vld[3] = 1'b1; m_val[3] = -8; q_val[3] = -1;
    drive();
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_pre", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_rspvalid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;

    // Randomized masks, operands and stalls against the model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        vld[i]   = ($urandom_range(0, 2) == 0);
        m_val[i] = rnd_op();
        q_val[i] = rnd_op();
      end
      drive();
      rsp_ready = 1'($urandom_range(0, 1));
      do_txn(int'($urandom_range(0, 3)), "rand", oid, oprod);
    end

`ifdef BOOTH_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
    drive();
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    chk("stat_clear0_grants", 64'(stat_grants), 64'd0);
    chk("stat_clear0_busy", 64'(stat_busy_cycles), 64'd0);
    vld[0] = 1'b1; m_val[0] = 2; q_val[0] = 3;
    drive();
    for (int t = 0; t < 3; t++) do_txn(0, "stat", oid, oprod);
    vld[0] = 1'b0;
    drive();
    chk("stat_grants", 64'(stat_grants), 64'd3);
    chk("stat_busy", 64'(stat_busy_cycles), 64'd6);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    chk("stat_clear_grants", 64'(stat_grants), 64'd0);
    chk("stat_clear_busy", 64'(stat_busy_cycles), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
